// File: rtl/microwave_timer.sv
// Microwave controller: door/start/cancel front panel, countdown cook timer,
// PWM heater power levels and a timed bell. Outputs are decoded from registered state.
module microwave_timer #(
    parameter int TIME_W     = 8,
    parameter int TICK_DIV   = 4,
    parameter int PWR_W      = 2,
    parameter int BELL_TICKS = 3
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              door,
    input  logic              start,
    input  logic              cancel,
    input  logic              load,
    input  logic [TIME_W-1:0] time_in,
    input  logic [PWR_W-1:0]  power,
    output logic              heat,
    output logic              light,
    output logic              bell,
    output logic [TIME_W-1:0] remaining,
    output logic              busy
);

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BELL_W = (BELL_TICKS > 0) ? $clog2(BELL_TICKS + 1) : 1;

    typedef enum logic [2:0] {
        S_CLOSED = 3'd0,
        S_OPEN   = 3'd1,
        S_COOK   = 3'd2,
        S_PAUSE  = 3'd3,
        S_HOLD   = 3'd4,
        S_RING   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [TIME_W-1:0]   r_remaining;
    logic [PRE_W-1:0]    r_presc;
    logic [PWR_W-1:0]    r_pwm;
    logic [BELL_W-1:0]   r_bell_cnt;
    logic                w_tick;
    logic                w_last_sec;
    logic                w_last_bell;
    logic                w_rem_zero;

    assign w_tick      = (r_presc == PRE_W'(TICK_DIV - 1));
    assign w_last_sec  = (r_remaining == TIME_W'(1));
    assign w_last_bell = (r_bell_cnt == BELL_W'(BELL_TICKS - 1));
    assign w_rem_zero  = (r_remaining == TIME_W'(0));
    assign remaining   = r_remaining;

    // State register
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= S_CLOSED;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; door outranks cancel, which outranks start
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLOSED: begin
                if (door)                       w_next = S_OPEN;
                else if (cancel)                w_next = S_CLOSED;
                else if (start && !w_rem_zero)  w_next = S_COOK;
                else                            w_next = S_CLOSED;
            end
            S_OPEN: begin
                if (!door) w_next = S_CLOSED;
                else       w_next = S_OPEN;
            end
            S_COOK: begin
                if (door)                     w_next = S_PAUSE;
                else if (cancel)              w_next = S_CLOSED;
                else if (w_tick && w_last_sec) w_next = S_RING;
                else                          w_next = S_COOK;
            end
            S_PAUSE: begin
                if (!door) w_next = S_HOLD;
                else       w_next = S_PAUSE;
            end
            S_HOLD: begin
                if (door)        w_next = S_PAUSE;
                else if (cancel) w_next = S_CLOSED;
                else if (start)  w_next = S_COOK;
                else             w_next = S_HOLD;
            end
            S_RING: begin
                if (door)                      w_next = S_OPEN;
                else if (w_tick && w_last_bell) w_next = S_CLOSED;
                else                           w_next = S_RING;
            end
            default: w_next = S_CLOSED;
        endcase
    end

    // Timer, prescaler, bell counter and PWM phase
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_remaining <= TIME_W'(0);
            r_presc     <= PRE_W'(0);
            r_bell_cnt  <= BELL_W'(0);
            r_pwm       <= PWR_W'(0);
        end else begin
            r_pwm <= ((r_state == S_COOK) && (w_next == S_COOK)) ? r_pwm + PWR_W'(1) : PWR_W'(0);
            case (r_state)
                S_CLOSED: begin
                    if (!door) begin
                        if (cancel) begin
                            r_remaining <= TIME_W'(0);
                        end else if (!(start && !w_rem_zero) && load) begin
                            r_remaining <= time_in;
                            r_presc     <= PRE_W'(0);
                        end
                    end
                end
                S_OPEN: begin
                    if (door && load) begin
                        r_remaining <= time_in;
                        r_presc     <= PRE_W'(0);
                    end
                end
                S_COOK: begin
                    // An exit coinciding with a tick wins: the partial second is kept
                    if (door) begin
                        r_presc <= r_presc;
                    end else if (cancel) begin
                        r_remaining <= TIME_W'(0);
                    end else if (w_tick) begin
                        r_presc <= PRE_W'(0);
                        if (w_last_sec) begin
                            r_remaining <= TIME_W'(0);
                            r_bell_cnt  <= BELL_W'(0);
                        end else begin
                            r_remaining <= r_remaining - TIME_W'(1);
                        end
                    end else begin
                        r_presc <= r_presc + PRE_W'(1);
                    end
                end
                S_HOLD: begin
                    if (!door && cancel) begin
                        r_remaining <= TIME_W'(0);
                    end
                end
                S_RING: begin
                    if (!door) begin
                        if (w_tick) begin
                            r_presc    <= PRE_W'(0);
                            r_bell_cnt <= r_bell_cnt + BELL_W'(1);
                        end else begin
                            r_presc <= r_presc + PRE_W'(1);
                        end
                    end
                end
                default: begin
                    r_presc <= r_presc;
                end
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        heat  = 1'b0;
        light = 1'b0;
        bell  = 1'b0;
        busy  = 1'b0;
        case (r_state)
            S_CLOSED: light = 1'b0;
            S_OPEN:   light = 1'b1;
            S_COOK: begin
                light = 1'b1;
                busy  = 1'b1;
                heat  = (r_pwm <= power);
            end
            S_PAUSE: begin
                light = 1'b1;
                busy  = 1'b1;
            end
            S_HOLD:  busy = 1'b1;
            S_RING:  bell = 1'b1;
            default: light = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_microwave_timer.sv
// Self-checking bench for microwave_timer: directed scenarios plus random
// stimulus, all compared against a cycle-count reference model.
module tb_microwave_timer;

    localparam int TIME_W     = 8;
    localparam int TICK_DIV   = 4;
    localparam int PWR_W      = 2;
    localparam int BELL_TICKS = 3;
    localparam int PWM_P      = 1 << PWR_W;
    localparam int RING_LEN   = BELL_TICKS * TICK_DIV;

    localparam int M_CLOSED = 0, M_OPEN = 1, M_COOK = 2, M_PAUSE = 3, M_HOLD = 4, M_RING = 5;

    logic              clk = 1'b0;
    logic              nrst, door, start, cancel, load;
    logic [TIME_W-1:0] time_in;
    logic [PWR_W-1:0]  power;
    logic              heat, light, bell, busy;
    logic [TIME_W-1:0] remaining;

    int checks = 0;
    int errors = 0;

    // Reference model: seconds left, cycles into the current second,
    // cycles since cooking (re)started, cycles spent ringing.
    int m_mode, m_rem, m_frac, m_phase, m_ring;

    microwave_timer #(
        .TIME_W(TIME_W), .TICK_DIV(TICK_DIV), .PWR_W(PWR_W), .BELL_TICKS(BELL_TICKS)
    ) dut (
        .clk(clk), .nrst(nrst), .door(door), .start(start), .cancel(cancel),
        .load(load), .time_in(time_in), .power(power), .heat(heat), .light(light),
        .bell(bell), .remaining(remaining), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [TIME_W+3:0] dut_vec();
        return {heat, light, bell, busy, remaining};
    endfunction

    function automatic logic [TIME_W+3:0] model_vec();
        logic h, l, b, bz;
        h  = (m_mode == M_COOK) && (m_phase <= int'(power));
        l  = (m_mode == M_OPEN) || (m_mode == M_COOK) || (m_mode == M_PAUSE);
        b  = (m_mode == M_RING);
        bz = (m_mode == M_COOK) || (m_mode == M_PAUSE) || (m_mode == M_HOLD);
        return {h, l, b, bz, TIME_W'(m_rem)};
    endfunction

    task automatic model_step();
        if (!nrst) begin
            m_mode = M_CLOSED; m_rem = 0; m_frac = 0; m_phase = 0; m_ring = 0;
        end else begin
            case (m_mode)
                M_CLOSED: begin
                    if (door) m_mode = M_OPEN;
                    else if (cancel) m_rem = 0;
                    else if (start && m_rem != 0) begin m_mode = M_COOK; m_phase = 0; end
                    else if (load) begin m_rem = int'(time_in); m_frac = 0; end
                end
                M_OPEN: begin
                    if (!door) m_mode = M_CLOSED;
                    else if (load) begin m_rem = int'(time_in); m_frac = 0; end
                end
                M_COOK: begin
                    if (door) m_mode = M_PAUSE;
                    else if (cancel) begin m_mode = M_CLOSED; m_rem = 0; end
                    else begin
                        m_phase = (m_phase + 1) % PWM_P;
                        m_frac  = m_frac + 1;
                        if (m_frac == TICK_DIV) begin
                            m_frac = 0;
                            m_rem  = m_rem - 1;
                            if (m_rem == 0) begin m_mode = M_RING; m_ring = 0; end
                        end
                    end
                end
                M_PAUSE: if (!door) m_mode = M_HOLD;
                M_HOLD: begin
                    if (door) m_mode = M_PAUSE;
                    else if (cancel) begin m_mode = M_CLOSED; m_rem = 0; end
                    else if (start) begin m_mode = M_COOK; m_phase = 0; end
                end
                M_RING: begin
                    if (door) m_mode = M_OPEN;
                    else begin
                        m_ring = m_ring + 1;
                        if (m_ring == RING_LEN) begin m_mode = M_CLOSED; m_frac = 0; end
                    end
                end
                default: m_mode = M_CLOSED;
            endcase
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        door = 1'b0; start = 1'b0; cancel = 1'b0; load = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        nrst = 1'b0;
        tick_clk();
        tick_clk();
        nrst = 1'b1;
    endtask

    task automatic load_and_start(input int t);
        load = 1'b1; time_in = TIME_W'(t);
        tick_clk();
        load = 1'b0; start = 1'b1;
        tick_clk();
        start = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0; start = 1'b1; load = 1'b1; door = 1'b0; cancel = 1'b0;
        time_in = 8'd7; power = 2'd3;
        tick_clk();
        tick_clk();
        checks++;
        if (dut_vec() !== {(TIME_W+4){1'b0}}) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", dut_vec());
        end
        nrst = 1'b1; idle();
        tick_clk();
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL reset_release got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_basic_cook();
        int bell_cycles;
        logic [TIME_W-1:0] exp_rem;
        apply_reset();
        power = 2'd3;
        load = 1'b1; time_in = 8'd2;
        tick_clk();
        load = 1'b0;
        checks++;
        if (remaining !== 8'd2) begin
            errors++; $display("FAIL basic_load got=%0d exp=2", remaining);
        end
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        bell_cycles = 0;
        for (int i = 0; i < 24; i++) begin
            exp_rem = (i < 4) ? 8'd2 : (i < 8) ? 8'd1 : 8'd0;
            bell_cycles += int'(bell);
            checks++;
            if (remaining !== exp_rem || busy !== (i < 8) || bell !== (i >= 8 && i < 20)) begin
                errors++;
                $display("FAIL basic_seq cyc=%0d got rem=%0d busy=%b bell=%b exp rem=%0d busy=%b bell=%b",
                         i, remaining, busy, bell, exp_rem, (i < 8), (i >= 8 && i < 20));
            end
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL basic_model cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            tick_clk();
        end
        checks++;
        if (bell_cycles != RING_LEN || dut_vec() !== {(TIME_W+4){1'b0}}) begin
            errors++; $display("FAIL basic_bell got=%0d cycles out=%h exp=%0d cycles out=0",
                               bell_cycles, dut_vec(), RING_LEN);
        end
    endtask

    task automatic test_pwm();
        apply_reset();
        power = 2'd1;
        load_and_start(3);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (heat !== ((i % 4) < 2)) begin
                errors++; $display("FAIL pwm_p1 cyc=%0d got=%b exp=%b", i, heat, ((i % 4) < 2));
            end
            tick_clk();
        end
        power = 2'd3;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (heat !== 1'b1 || dut_vec() !== model_vec()) begin
                errors++; $display("FAIL pwm_p3 cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            tick_clk();
        end
    endtask

    task automatic test_pause_resume();
        apply_reset();
        power = 2'd0;
        load_and_start(3);
        tick_clk();
        tick_clk();
        door = 1'b1;
        tick_clk();
        checks++;
        if (heat !== 1'b0 || light !== 1'b1 || remaining !== 8'd3 || busy !== 1'b1) begin
            errors++; $display("FAIL pause got h=%b l=%b rem=%0d exp h=0 l=1 rem=3", heat, light, remaining);
        end
        door = 1'b0;
        tick_clk();
        checks++;
        if (light !== 1'b0 || busy !== 1'b1 || dut_vec() !== model_vec()) begin
            errors++; $display("FAIL hold got=%h exp=%h", dut_vec(), model_vec());
        end
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        tick_clk();
        checks++;
        if (remaining !== 8'd3) begin
            errors++; $display("FAIL resume_partial got=%0d exp=3", remaining);
        end
        tick_clk();
        checks++;
        if (remaining !== 8'd2 || dut_vec() !== model_vec()) begin
            errors++; $display("FAIL resume_tick got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_cancel();
        apply_reset();
        load_and_start(2);
        door = 1'b1; tick_clk();
        door = 1'b0; tick_clk();
        cancel = 1'b1; start = 1'b1;
        tick_clk();
        cancel = 1'b0;
        checks++;
        if (remaining !== 8'd0 || busy !== 1'b0 || dut_vec() !== model_vec()) begin
            errors++; $display("FAIL cancel got=%h exp=%h", dut_vec(), model_vec());
        end
        tick_clk();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || light !== 1'b0) begin
            errors++; $display("FAIL start_zero got busy=%b light=%b exp 0 0", busy, light);
        end
    endtask

    task automatic test_exit_on_tick();
        apply_reset();
        power = 2'd2;
        load_and_start(2);
        for (int i = 0; i < 7; i++) tick_clk();
        door = 1'b1;
        tick_clk();
        checks++;
        if (remaining !== 8'd1 || bell !== 1'b0 || busy !== 1'b1 || dut_vec() !== model_vec()) begin
            errors++; $display("FAIL door_on_tick got=%h exp=%h", dut_vec(), model_vec());
        end
        door = 1'b0; tick_clk();
        start = 1'b1; tick_clk();
        start = 1'b0; tick_clk();
        checks++;
        if (bell !== 1'b1 || remaining !== 8'd0) begin
            errors++; $display("FAIL ring_entry got bell=%b rem=%0d exp bell=1 rem=0", bell, remaining);
        end
        tick_clk(); tick_clk();
        door = 1'b1;
        tick_clk();
        checks++;
        if (bell !== 1'b0 || light !== 1'b1 || dut_vec() !== model_vec()) begin
            errors++; $display("FAIL ring_door got=%h exp=%h", dut_vec(), model_vec());
        end
        door = 1'b0; tick_clk();
    endtask

    task automatic test_reset_mid_cook();
        apply_reset();
        power = 2'd3;
        load_and_start(6);
        for (int i = 0; i < 4; i++) tick_clk();
        checks++;
        if (remaining !== 8'd5) begin
            errors++; $display("FAIL pre_reset got=%0d exp=5", remaining);
        end
        nrst = 1'b0; start = 1'b1;
        tick_clk();
        nrst = 1'b1;
        checks++;
        if (dut_vec() !== {(TIME_W+4){1'b0}}) begin
            errors++; $display("FAIL mid_reset got=%h exp=0", dut_vec());
        end
        tick_clk();
        start = 1'b0;
        checks++;
        if (dut_vec() !== {(TIME_W+4){1'b0}} || dut_vec() !== model_vec()) begin
            errors++; $display("FAIL post_reset_start got=%h exp=0", dut_vec());
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            nrst    = ($urandom_range(0, 199) != 0);
            door    = ($urandom_range(0, 99) < 8);
            cancel  = ($urandom_range(0, 99) < 3);
            start   = ($urandom_range(0, 99) < 25);
            load    = ($urandom_range(0, 99) < 10);
            time_in = TIME_W'($urandom_range(0, 4));
            power   = PWR_W'($urandom_range(0, PWM_P - 1));
            tick_clk();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        idle();
    endtask

    initial begin
        nrst = 1'b0; idle(); time_in = 8'd0; power = 2'd0;
        m_mode = M_CLOSED; m_rem = 0; m_frac = 0; m_phase = 0; m_ring = 0;
        test_reset();
        test_basic_cook();
        test_pwm();
        test_pause_resume();
        test_cancel();
        test_exit_on_tick();
        test_reset_mid_cook();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/microwave_timer.md
Name: microwave_timer

Overview:
Parametrised microwave controller. It has a programmable countdown cook timer, pulse-width power levels, and a timed bell. It adds pause/hold/resume and cancel on top of the basic door/start/finish controller; the internal timer replaces the external `finish` input. It sits between the front-panel input logic and the heater/lamp/bell drivers.

Parameters:
- TIME_W, 8: width of the cook-time counter, in seconds.
- TICK_DIV, 4: clock cycles per one-second tick. Must be ≥ 2.
- PWR_W, 2: width of the power-level input. The PWM period is 2**PWR_W cycles.
- BELL_TICKS, 3: bell duration, in ticks. Must be ≥ 1.

Ports:
- clk, in, 1: clock. Everything is on the rising edge.
- nrst, in, 1: synchronous active-low reset.
- door, in, 1: 1 means the door is open.
- start, in, 1: begin or resume cooking.
- cancel, in, 1: abort and clear the remaining time.
- load, in, 1: load `time_in` into the timer.
- time_in, in, TIME_W: cook time, in seconds.
- power, in, PWR_W: power level, sampled every cycle.
- heat, out, 1: heater drive.
- light, out, 1: lamp.
- bell, out, 1: bell.
- remaining, out, TIME_W: seconds left, for the display.
- busy, out, 1: high in COOK, PAUSE and HOLD.

Behaviour:
- Reset is synchronous and active-low. When `nrst`=0 at a clk edge:
  - state ← CLOSED; remaining, prescaler, pwm_cnt and bell_cnt ← 0.
  - Resulting outputs: heat=0, light=0, bell=0, busy=0, remaining=0.
  - Reset mid-cook aborts immediately with no residue.
- Input priority within a state is door > cancel > start > load. Inputs are sampled raw, not edge-detected.
- Outputs are Moore-style (decoded from registered state and counters), so they change one cycle after the input that causes them:
  - CLOSED: all outputs 0.
  - OPEN: light=1.
  - COOK: light=1; heat = (pwm_cnt <= power).
  - PAUSE: light=1.
  - HOLD: all outputs 0 except busy.
  - RING: bell=1.
- State transitions:
  - CLOSED:
    - door → OPEN.
    - start with remaining≠0 → COOK. start with remaining=0 is ignored.
    - load → remaining ← time_in; prescaler ← 0.
  - OPEN:
    - !door → CLOSED.
    - load is accepted while the door is open (remaining ← time_in).
  - COOK:
    - door → PAUSE.
    - cancel → CLOSED, remaining ← 0.
    - Otherwise the countdown runs, as described below.
    - load and start are ignored.
  - PAUSE: !door → HOLD. cancel is ignored (door has priority).
  - HOLD:
    - door → PAUSE.
    - cancel → CLOSED, remaining ← 0.
    - start → COOK.
  - RING:
    - door → OPEN, bell stops the next cycle.
    - After BELL_TICKS ticks → CLOSED.
- Countdown:
  - In COOK the prescaler counts 0..TICK_DIV-1 and wraps. The wrap is a tick.
  - On a tick, remaining decrements by 1.
  - A tick with remaining=1 sets remaining ← 0 and moves to RING with prescaler ← 0 and bell_cnt ← 0.
  - First tick after entering COOK from CLOSED: TICK_DIV cycles after `heat` first asserts.
  - The prescaler holds its value in PAUSE/HOLD, so a resume continues the partial second.
  - If door or cancel coincides with a tick, the exit wins: no decrement, prescaler holds.
- PWM:
  - pwm_cnt is free-running modulo 2**PWR_W while in COOK, and reset to 0 on every entry to COOK.
  - power=2**PWR_W-1 gives 100% heat. power=0 gives 1 cycle in 2**PWR_W.
- Bell: in RING the prescaler runs. bell_cnt increments per tick; reaching BELL_TICKS moves to CLOSED.
  - Bell is high for exactly BELL_TICKS*TICK_DIV cycles if the door is not opened.
- Width and wrap:
  - remaining never underflows: no decrement at 0, and COOK is never entered with 0.
  - time_in is taken at full width with no saturation.

Test Plan:
Defaults for all scenarios: TICK_DIV=4, PWR_W=2, BELL_TICKS=3.
1. load time_in=2 in CLOSED, then start, door=0 throughout.
   - busy=1; remaining goes 2→1→0 at 4-cycle intervals.
   - bell=1 for exactly 12 cycles, then CLOSED with all outputs 0.
2. power=1 during COOK → heat pattern 1,1,0,0 repeating from COOK entry. power=3 → heat constantly 1.
3. time_in=3, door=1 two cycles into the first second.
   - PAUSE: heat=0, light=1, remaining=3.
   - Close door → HOLD, light=0. start → COOK; first decrement arrives after the 2 cycles left in that second.
4. HOLD with remaining=2, cancel=1 and start=1 in the same cycle → CLOSED, remaining=0, busy=0. A later start with remaining=0 stays in CLOSED.
5. Door opened on the cycle where remaining=1 and a tick coincide → PAUSE with remaining=1, no RING. Also: door during RING → OPEN, bell=0 the next cycle.
6. nrst=0 for one cycle mid-COOK with remaining=5 → next cycle all outputs 0 and remaining=0. A start while nrst=0 is ignored.
